// File: rtl/vmicro16_apb_pkg.sv
// Shared APB slave definitions for vmicro16 peripherals: port widths,
// timer register offsets and timer CTRL bit positions.
package vmicro16_apb_pkg;

  // APB slave port widths reused by every peripheral on the fabric
  localparam int APB_BUS_WIDTH  = 16;
  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_REG_SEL_W  = 3;

  // Timer register offsets (decoded from PADDR[2:0])
  localparam logic [APB_REG_SEL_W-1:0] TIMER_CTRL     = 3'd0;
  localparam logic [APB_REG_SEL_W-1:0] TIMER_LOAD     = 3'd1;
  localparam logic [APB_REG_SEL_W-1:0] TIMER_VALUE    = 3'd2;
  localparam logic [APB_REG_SEL_W-1:0] TIMER_PRESCALE = 3'd3;
  localparam logic [APB_REG_SEL_W-1:0] TIMER_STATUS   = 3'd4;

  // CTRL bit positions
  localparam int CTRL_EN          = 0;
  localparam int CTRL_AUTO_RELOAD = 1;
  localparam int CTRL_INT_EN      = 2;
  localparam int CTRL_W           = 3;

  // STATUS bit positions
  localparam int STATUS_EXPIRED   = 0;

endpackage

// File: rtl/vmicro16_prescaler.sv
// Timer prescaler: emits a one-cycle tick every (limit+1) enabled cycles.
// The count is cleared while disabled or on clr, so enabling always starts
// a fresh period. Lowering limit below the current count lets the counter
// wrap through all-ones back to zero before the next compare.
module vmicro16_prescaler #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic [BUS_WIDTH-1:0] limit,
  output logic                 tick
);

  logic [BUS_WIDTH-1:0] pcnt;

  assign tick = en & (pcnt == limit);

  // Prescale counter: restart on clear/disable/tick, otherwise count up
  always_ff @(posedge clk) begin
    if (reset || !en || clr) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + BUS_WIDTH'(1);
    end
  end

endmodule

// File: rtl/vmicro16_apb_timer.sv
// APB3 slave down-counting timer with prescaler, auto-reload and a level
// interrupt. Zero wait states: PREADY is the access phase itself. Register
// writes take priority over same-cycle timer events, except that a fresh
// expiry beats a STATUS clear so no expiry is ever lost.
module vmicro16_apb_timer
  import vmicro16_apb_pkg::*;
#(
  parameter int                   BUS_WIDTH      = APB_BUS_WIDTH,
  parameter int                   ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter logic [BUS_WIDTH-1:0] PRESCALE_RESET = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] S_PADDR,
  input  logic                  S_PWRITE,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic [BUS_WIDTH-1:0]  S_PWDATA,
  output logic [BUS_WIDTH-1:0]  S_PRDATA,
  output logic                  S_PREADY,
  output logic                  int_o
);

  // Down-count that never goes below zero
  function automatic logic [BUS_WIDTH-1:0] dec_sat(input logic [BUS_WIDTH-1:0] v);
    return (v == '0) ? '0 : v - BUS_WIDTH'(1);
  endfunction

  logic [APB_REG_SEL_W-1:0] sel;
  logic                     access;
  logic                     wr;
  logic                     rd;

  logic [CTRL_W-1:0]        ctrl;
  logic [BUS_WIDTH-1:0]     load;
  logic [BUS_WIDTH-1:0]     value;
  logic [BUS_WIDTH-1:0]     prescale;
  logic                     expired;

  logic                     tick;
  logic                     tick_act;
  logic                     expire_set;
  logic                     w1c;
  logic                     wr_ctrl;
  logic                     wr_load;
  logic                     wr_prescale;
  logic                     wr_status;
  logic [BUS_WIDTH-1:0]     rdata_mux;

  // Only the low address bits select a register
  logic unused_addr;
  assign unused_addr = ^S_PADDR[ADDR_WIDTH-1:APB_REG_SEL_W];

  assign sel    = S_PADDR[APB_REG_SEL_W-1:0];
  assign access = S_PSELx & S_PENABLE;
  assign wr     = access & S_PWRITE;
  assign rd     = access & ~S_PWRITE;

  // Write strobe decode; VALUE and unmapped offsets get no strobe
  always_comb begin
    wr_ctrl     = 1'b0;
    wr_load     = 1'b0;
    wr_prescale = 1'b0;
    wr_status   = 1'b0;
    if (wr) begin
      case (sel)
        TIMER_CTRL:     wr_ctrl     = 1'b1;
        TIMER_LOAD:     wr_load     = 1'b1;
        TIMER_PRESCALE: wr_prescale = 1'b1;
        TIMER_STATUS:   wr_status   = 1'b1;
        default:        ;
      endcase
    end
  end

  // A LOAD write or a CTRL write that disables the timer swallows the tick
  assign tick_act   = tick & ~wr_load & ~(wr_ctrl & ~S_PWDATA[CTRL_EN]);
  assign expire_set = tick_act & (value == '0);
  assign w1c        = wr_status & S_PWDATA[STATUS_EXPIRED];

  vmicro16_prescaler #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl[CTRL_EN]),
    .clr   (wr_load),
    .limit (prescale),
    .tick  (tick)
  );

  // Timer core and register file; later assignments give writes priority
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= '0;
      load     <= '0;
      value    <= '0;
      prescale <= PRESCALE_RESET;
      expired  <= 1'b0;
    end else begin
      if (tick_act) begin
        if (expire_set) begin
          if (ctrl[CTRL_AUTO_RELOAD]) begin
            value <= load;
          end else begin
            ctrl[CTRL_EN] <= 1'b0;
          end
        end else begin
          value <= dec_sat(value);
        end
      end
      if (expire_set) begin
        expired <= 1'b1;
      end else if (w1c) begin
        expired <= 1'b0;
      end
      if (wr_ctrl) begin
        ctrl <= S_PWDATA[CTRL_W-1:0];
      end
      if (wr_load) begin
        load  <= S_PWDATA;
        value <= S_PWDATA;
      end
      if (wr_prescale) begin
        prescale <= S_PWDATA;
      end
    end
  end

  // Read data selection
  always_comb begin
    rdata_mux = '0;
    case (sel)
      TIMER_CTRL:     rdata_mux = {{(BUS_WIDTH-CTRL_W){1'b0}}, ctrl};
      TIMER_LOAD:     rdata_mux = load;
      TIMER_VALUE:    rdata_mux = value;
      TIMER_PRESCALE: rdata_mux = prescale;
      TIMER_STATUS:   rdata_mux = {{(BUS_WIDTH-1){1'b0}}, expired};
      default:        rdata_mux = '0;
    endcase
  end

  assign S_PREADY = access & ~reset;
  assign S_PRDATA = (rd & ~reset) ? rdata_mux : '0;
  assign int_o    = expired & ctrl[CTRL_INT_EN];

endmodule

// File: tb/tb_vmicro16_apb_timer.sv
// Directed bench for the APB timer: read expectations are queued when a
// read is issued and compared when the access phase presents PRDATA.
module tb_vmicro16_apb_timer;
  import vmicro16_apb_pkg::*;

  localparam int BW = 16;
  localparam int AW = 8;

  localparam logic [AW-1:0] A_CTRL = AW'(TIMER_CTRL);
  localparam logic [AW-1:0] A_LOAD = AW'(TIMER_LOAD);
  localparam logic [AW-1:0] A_VAL  = AW'(TIMER_VALUE);
  localparam logic [AW-1:0] A_PRE  = AW'(TIMER_PRESCALE);
  localparam logic [AW-1:0] A_STAT = AW'(TIMER_STATUS);

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] paddr;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [BW-1:0] pwdata;
  logic [BW-1:0] prdata;
  logic          pready;
  logic          int_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string         tag;
    logic [BW-1:0] data;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  vmicro16_apb_timer #(
    .BUS_WIDTH      (BW),
    .ADDR_WIDTH     (AW),
    .PRESCALE_RESET ('0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .S_PADDR   (paddr),
    .S_PWRITE  (pwrite),
    .S_PSELx   (psel),
    .S_PENABLE (penable),
    .S_PWDATA  (pwdata),
    .S_PRDATA  (prdata),
    .S_PREADY  (pready),
    .int_o     (int_o)
  );

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_int(input logic exp, input string tag);
    check(tag, BW'(int_o), BW'(exp));
  endtask

  // Called at a negedge; returns at the negedge after the commit edge
  task automatic apb_write(input logic [AW-1:0] a, input logic [BW-1:0] d, input string tag);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    #1 check({tag, "_setup_rdy"}, BW'(pready), '0);
    @(negedge clk);
    penable = 1'b1;
    #1 check({tag, "_rdy"}, BW'(pready), BW'(1));
    @(negedge clk);
    bus_idle();
  endtask

  task automatic apb_read(input logic [AW-1:0] a, input logic [BW-1:0] exp, input string tag);
    exp_t e;
    e.tag  = tag;
    e.data = exp;
    sbq.push_back(e);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    #1 check({tag, "_setup_rdy"}, BW'(pready), '0);
    @(negedge clk);
    penable = 1'b1;
    #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = sbq.pop_front();
      check(e.tag, prdata, e.data);
    end
    check({tag, "_rdy"}, BW'(pready), BW'(1));
    @(negedge clk);
    bus_idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_idle();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check_int(1'b0, "rst_int");
    for (int a = 0; a < 8; a++) apb_read(AW'(a), '0, $sformatf("rst_rd%0d", a));

    // One-shot, prescale 0: ticks every cycle after enable
    apb_write(A_PRE, 16'h0000, "os_pre");
    apb_write(A_LOAD, 16'h0003, "os_load");
    apb_write(A_CTRL, 16'h0005, "os_ctrl");
    apb_read(A_VAL, 16'h0002, "os_val2");
    apb_read(A_VAL, 16'h0000, "os_val0");
    check_int(1'b1, "os_int");
    apb_read(A_STAT, 16'h0001, "os_stat");
    apb_read(A_CTRL, 16'h0004, "os_en_off");
    apb_read(A_VAL, 16'h0000, "os_val_hold");
    apb_write(A_STAT, 16'h0001, "os_w1c");
    apb_read(A_STAT, 16'h0000, "os_stat_clr");
    check_int(1'b0, "os_int_clr");

    // Same one-shot, read offset by one cycle to observe VALUE=1
    apb_write(A_LOAD, 16'h0003, "os2_load");
    apb_write(A_CTRL, 16'h0005, "os2_ctrl");
    idle(1);
    apb_read(A_VAL, 16'h0001, "os_val1");
    idle(3);
    apb_read(A_STAT, 16'h0001, "os2_stat");
    apb_write(A_STAT, 16'h0001, "os2_w1c");
    apb_read(A_STAT, 16'h0000, "os2_stat_clr");

    // Auto-reload, prescale 2: tick every 3 cycles, expiry every 6
    apb_write(A_PRE, 16'h0002, "ar_pre");
    apb_write(A_LOAD, 16'h0001, "ar_load");
    apb_write(A_CTRL, 16'h0007, "ar_ctrl");
    apb_read(A_VAL, 16'h0001, "ar_val_a");
    apb_read(A_VAL, 16'h0000, "ar_val_b");
    apb_read(A_STAT, 16'h0000, "ar_stat_pre");
    apb_read(A_VAL, 16'h0001, "ar_reload");
    check_int(1'b1, "ar_int");
    apb_read(A_STAT, 16'h0001, "ar_stat");
    // This W1C commits on the second expiry edge: the set must win
    apb_write(A_STAT, 16'h0001, "col_w1c");
    check_int(1'b1, "col_int_hold");
    apb_write(A_STAT, 16'h0001, "clr_w1c");
    check_int(1'b0, "clr_int");
    apb_read(A_STAT, 16'h0000, "clr_stat");
    // Disabling CTRL write lands on the third expiry tick: tick is dropped
    apb_write(A_CTRL, 16'h0000, "stop_ctrl");
    apb_read(A_STAT, 16'h0000, "ctrlcol_stat");
    apb_read(A_VAL, 16'h0000, "ctrlcol_val");
    check_int(1'b0, "ctrlcol_int");

    // Read-only and unmapped addresses
    apb_write(A_LOAD, 16'h0055, "um_load");
    apb_write(AW'(2), 16'hBEEF, "um_wr2");
    apb_write(AW'(5), 16'hBEEF, "um_wr5");
    apb_write(AW'(7), 16'hBEEF, "um_wr7");
    apb_read(A_VAL, 16'h0055, "um_val");
    apb_read(AW'(5), 16'h0000, "um_rd5");
    apb_read(AW'(7), 16'h0000, "um_rd7");
    apb_read(A_LOAD, 16'h0055, "um_load_rd");
    apb_read(A_CTRL, 16'h0000, "um_ctrl");
    apb_read(A_PRE, 16'h0002, "um_pre");
    apb_read(A_STAT, 16'h0000, "um_stat");

    // Reset while counting, with a write in its access phase
    apb_write(A_PRE, 16'h0000, "rm_pre");
    apb_write(A_LOAD, 16'h0100, "rm_load");
    apb_write(A_CTRL, 16'h0005, "rm_ctrl");
    idle(3);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_LOAD; pwdata = 16'h1234;
    @(negedge clk);
    penable = 1'b1;
    reset   = 1'b1;
    #1 check("rm_rdy_in_reset", BW'(pready), '0);
    @(negedge clk);
    reset = 1'b0;
    bus_idle();
    check_int(1'b0, "rm_int");
    for (int a = 0; a < 8; a++) apb_read(AW'(a), '0, $sformatf("rm_rd%0d", a));
    idle(5);
    apb_read(A_VAL, 16'h0000, "rm_noticks");
    apb_read(A_LOAD, 16'h0000, "rm_load_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
